// File: rtl/rv32i_cycle_sequencer.sv
// rv32i_cycle_sequencer
//   Multi-cycle control FSM for the RV32I core. Each instruction walks
//   FETCH -> DECODE -> EXEC -> (MEM) -> WB over one shared memory port.
//   A memory request that goes unacknowledged for MEM_TIMEOUT cycles, or an
//   illegal opcode, parks the sequencer in HALT until reset.
// Ports
//   clk, nReset           clock (rising edge), async active-low reset
//   run                   start/continue; low stops at next instruction boundary
//   memAck                memory completes the current request this cycle
//   dec*                  decoder control flags (stable DECODE..WB)
//   branchTaken           branch-condition result
//   memReq/memWrite/memIsFetch  shared memory port request
//   irLoad                latch fetched word into IR
//   pcWrite/pcBranch      PC update and source select
//   regWrite/regWriteSel  register-file write enable and rd source
//   halted/fault          HALT state and its cause
//   instret               retired-instruction count (wraps)
module rv32i_cycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             run,
  input  logic             memAck,
  input  logic             decRegWrite,
  input  logic             decLinkWrite,
  input  logic             decTestBranch,
  input  logic             decAlwaysBranch,
  input  logic             decRAMRead,
  input  logic             decRAMWrite,
  input  logic             decIllegal,
  input  logic             branchTaken,
  output logic             memReq,
  output logic             memWrite,
  output logic             memIsFetch,
  output logic             irLoad,
  output logic             pcWrite,
  output logic             pcBranch,
  output logic             regWrite,
  output logic [1:0]       regWriteSel,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  state_t        state;
  logic [TW-1:0] tmoCnt;
  logic          faultQ;
  logic          tmoLast;

  // Last allowed cycle of a request: an ack here is still honoured,
  // otherwise the request times out.
  assign tmoLast = (tmoCnt == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      tmoCnt  <= '0;
      instret <= '0;
      faultQ  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state  <= FETCH;
            tmoCnt <= '0;
          end
        end
        FETCH, MEM: begin
          if (memAck) begin
            state <= (state == FETCH) ? DECODE : WB;
          end else if (tmoLast) begin
            state  <= HALT;
            faultQ <= 1'b1;
          end else begin
            tmoCnt <= tmoCnt + TW'(1);
          end
        end
        DECODE: begin
          if (decIllegal) begin
            state  <= HALT;
            faultQ <= 1'b1;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (decRAMRead | decRAMWrite) begin
            state  <= MEM;
            tmoCnt <= '0;
          end else begin
            state <= WB;
          end
        end
        WB: begin
          instret <= instret + CNT_W'(1);
          tmoCnt  <= '0;
          state   <= run ? FETCH : IDLE;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state (and memAck/decoder flags) so irLoad
  // coincides with the acknowledging cycle.
  always_comb begin
    memReq      = 1'b0;
    memWrite    = 1'b0;
    memIsFetch  = 1'b0;
    irLoad      = 1'b0;
    pcWrite     = 1'b0;
    pcBranch    = 1'b0;
    regWrite    = 1'b0;
    regWriteSel = 2'd0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        memReq     = 1'b1;
        memIsFetch = 1'b1;
        irLoad     = memAck;
      end
      MEM: begin
        memReq   = 1'b1;
        memWrite = decRAMWrite;
      end
      WB: begin
        pcWrite  = 1'b1;
        pcBranch = decAlwaysBranch | (decTestBranch & branchTaken);
        // A store carries both RAM flags; it never writes rd.
        regWrite = decRegWrite & ~decRAMWrite;
        if (decLinkWrite)                    regWriteSel = 2'd2;
        else if (decRAMRead & ~decRAMWrite)  regWriteSel = 2'd1;
        else                                 regWriteSel = 2'd0;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign fault = faultQ;

endmodule

// File: tb/tb_rv32i_cycle_sequencer.sv
module tb_rv32i_cycle_sequencer;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        run = 1'b0;
  logic        memAck = 1'b0;
  logic        decRegWrite = 1'b0, decLinkWrite = 1'b0, decTestBranch = 1'b0;
  logic        decAlwaysBranch = 1'b0, decRAMRead = 1'b0, decRAMWrite = 1'b0;
  logic        decIllegal = 1'b0, branchTaken = 1'b0;
  logic        memReq, memWrite, memIsFetch, irLoad, pcWrite, pcBranch, regWrite;
  logic [1:0]  regWriteSel;
  logic        halted, fault;
  logic [31:0] instret;

  rv32i_cycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .nReset(nReset), .run(run), .memAck(memAck),
    .decRegWrite(decRegWrite), .decLinkWrite(decLinkWrite),
    .decTestBranch(decTestBranch), .decAlwaysBranch(decAlwaysBranch),
    .decRAMRead(decRAMRead), .decRAMWrite(decRAMWrite),
    .decIllegal(decIllegal), .branchTaken(branchTaken),
    .memReq(memReq), .memWrite(memWrite), .memIsFetch(memIsFetch),
    .irLoad(irLoad), .pcWrite(pcWrite), .pcBranch(pcBranch),
    .regWrite(regWrite), .regWriteSel(regWriteSel),
    .halted(halted), .fault(fault), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        memReq, memWrite, memIsFetch, irLoad, pcWrite, pcBranch, regWrite;
    logic [1:0]  sel;
    logic        halted, fault;
    logic [31:0] cnt;
  } exp_t;

  // {RegWrite, LinkWrite, TestBranch, AlwaysBranch, RAMRead, RAMWrite, Illegal, branchTaken}
  localparam logic [7:0] D_ALU   = 8'b1000_0000;
  localparam logic [7:0] D_LOAD  = 8'b1000_1000;
  localparam logic [7:0] D_STORE = 8'b1000_1100;
  localparam logic [7:0] D_BNT   = 8'b0010_0000;
  localparam logic [7:0] D_BT    = 8'b0010_0001;
  localparam logic [7:0] D_JAL   = 8'b1101_0000;
  localparam logic [7:0] D_ILL   = 8'b0000_0010;

  exp_t        expQ[$];
  string       tagQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  decQ = 8'h00;
  int unsigned ret = 0;   // expected instret

  function automatic exp_t eIdle();
    exp_t e = '0;
    e.cnt = ret;
    return e;
  endfunction
  function automatic exp_t eFetch(input logic ld);
    exp_t e = '0;
    e.memReq = 1'b1; e.memIsFetch = 1'b1; e.irLoad = ld; e.cnt = ret;
    return e;
  endfunction
  function automatic exp_t eMem(input logic w);
    exp_t e = '0;
    e.memReq = 1'b1; e.memWrite = w; e.cnt = ret;
    return e;
  endfunction
  function automatic exp_t eWb(input logic br, input logic rw, input logic [1:0] sel);
    exp_t e = '0;
    e.pcWrite = 1'b1; e.pcBranch = br; e.regWrite = rw; e.sel = sel; e.cnt = ret;
    return e;
  endfunction
  function automatic exp_t eHalt();
    exp_t e = '0;
    e.halted = 1'b1; e.fault = 1'b1; e.cnt = ret;
    return e;
  endfunction

  // One clock cycle of stimulus; the expected outputs for that cycle go
  // to the scoreboard.
  task automatic cyc(input logic rs, input logic r, input logic a, input exp_t e, input string tag);
    @(posedge clk);
    #1;
    nReset = rs; run = r; memAck = a;
    {decRegWrite, decLinkWrite, decTestBranch, decAlwaysBranch,
     decRAMRead, decRAMWrite, decIllegal, branchTaken} = decQ;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic aluLike(input logic [7:0] d, input logic br, input logic rw, input logic [1:0] sel);
    decQ = d;
    cyc(1, 1, 1, eFetch(1), "fetch");
    cyc(1, 1, 0, eIdle(),   "decode");
    cyc(1, 1, 0, eIdle(),   "exec");
    cyc(1, 1, 0, eWb(br, rw, sel), "wb");
    ret++;
  endtask

  task automatic memInstr(input logic [7:0] d, input int nMem, input logic w,
                          input logic rw, input logic [1:0] sel);
    decQ = d;
    cyc(1, 1, 1, eFetch(1), "fetch");
    cyc(1, 1, 0, eIdle(),   "decode");
    cyc(1, 1, 0, eIdle(),   "exec");
    for (int i = 1; i <= nMem; i++) cyc(1, 1, (i == nMem), eMem(w), "mem");
    cyc(1, 1, 0, eWb(1'b0, rw, sel), "wb");
    ret++;
  endtask

  // Monitor: compare DUT outputs against the scoreboard mid-cycle.
  initial begin
    exp_t  e, got;
    string t;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        t = tagQ.pop_front();
        got = {memReq, memWrite, memIsFetch, irLoad, pcWrite, pcBranch, regWrite,
               regWriteSel, halted, fault, instret};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s @%0t: got %h expected %h", t, $time, got, e);
        end
      end
    end
  end

  initial begin
    // reset held
    cyc(0, 0, 0, eIdle(), "reset");
    cyc(0, 0, 0, eIdle(), "reset");
    // release with run=1, fetch acked on third cycle
    decQ = D_ALU;
    cyc(1, 1, 0, eIdle(),   "idle_run");
    cyc(1, 1, 0, eFetch(0), "fetch_w1");
    cyc(1, 1, 0, eFetch(0), "fetch_w2");
    cyc(1, 1, 1, eFetch(1), "fetch_ack");
    cyc(1, 1, 0, eIdle(),   "decode");
    cyc(1, 1, 0, eIdle(),   "exec");
    cyc(1, 1, 0, eWb(0, 1, 2'd0), "wb_alu");
    ret++;
    aluLike(D_ALU, 0, 1, 2'd0);                // zero-wait ALU op
    memInstr(D_LOAD, 5, 0, 1, 2'd1);           // load, ack in 5th MEM cycle
    memInstr(D_STORE, 1, 1, 0, 2'd0);          // store: write, no rd write
    aluLike(D_BNT, 0, 0, 2'd0);                // branch not taken
    aluLike(D_BT,  1, 0, 2'd0);                // branch taken
    aluLike(D_JAL, 1, 1, 2'd2);                // jal: link
    memInstr(D_LOAD, 16, 0, 1, 2'd1);          // ack in last allowed cycle
    // drop run mid-instruction: completes, then IDLE
    decQ = D_ALU;
    cyc(1, 1, 1, eFetch(1), "fetch");
    cyc(1, 0, 0, eIdle(),   "decode_norun");
    cyc(1, 0, 0, eIdle(),   "exec_norun");
    cyc(1, 0, 0, eWb(0, 1, 2'd0), "wb_norun");
    ret++;
    cyc(1, 0, 0, eIdle(),   "idle_stay");
    cyc(1, 1, 0, eIdle(),   "idle_run");
    // fetch timeout
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, eFetch(0), "fetch_tmo");
    for (int i = 0; i < 4; i++)  cyc(1, i[0], 1, eHalt(), "halt_tmo");
    // reset pulse out of HALT
    ret = 0;
    cyc(0, 0, 0, eIdle(), "reset_pulse");
    cyc(1, 1, 0, eIdle(), "idle_run");
    // illegal opcode
    decQ = D_ILL;
    cyc(1, 1, 1, eFetch(1), "fetch");
    cyc(1, 1, 0, eIdle(),   "decode_ill");
    cyc(1, 0, 1, eHalt(),   "halt_ill");
    cyc(1, 1, 0, eHalt(),   "halt_ill");
    // reset asserted mid-request
    cyc(0, 0, 0, eIdle(),   "reset");
    decQ = D_ALU;
    cyc(1, 1, 0, eIdle(),   "idle_run");
    cyc(1, 1, 0, eFetch(0), "fetch");
    cyc(0, 1, 0, eIdle(),   "reset_midreq");
    cyc(1, 0, 0, eIdle(),   "idle_after");
    repeat (2) @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
